// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: bimodal BHT prediction at fetch, EX-stage mispredict redirect/flush,
// two-cycle recovery FSM and branch/mispredict performance counters.
module branch_predict_ctrl #(
   parameter int IDX_W = 4,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] if_pc,
   input  logic            if_is_branch,
   output logic            if_pred_taken,
   input  logic            ex_valid,
   input  logic            ex_is_branch,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_pred_taken,
   input  logic            ex_taken,
   input  logic [XLEN-1:0] ex_target,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush_if_id,
   output logic            flush_id_ex,
   output logic            busy_recover,
   output logic [31:0]     branch_cnt,
   output logic [31:0]     mispred_cnt
);
   localparam int N = 1 << IDX_W;
   typedef enum logic {RUN, RECOVER} state_t;
   state_t           state_q, state_d;
   logic [1:0]       rec_cnt_q, rec_cnt_d;
   logic [1:0]       bht_q [N];
   logic [1:0]       bht_d [N];
   logic [31:0]      branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;
   logic [IDX_W-1:0] if_idx, ex_idx;
   logic [1:0]       ctr;
   logic             res, mis;
   logic             unused_pc;
   assign unused_pc = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};
   always_comb begin
      if_idx        = if_pc[IDX_W+1:2];
      ex_idx        = ex_pc[IDX_W+1:2];
      res           = rst_n & ex_valid & ex_is_branch & (state_q == RUN);
      mis           = res & (ex_taken != ex_pred_taken);
      ctr           = bht_q[ex_idx];
      if_pred_taken = rst_n & if_is_branch & bht_q[if_idx][1];
      redirect      = mis;
      flush_if_id   = mis;
      flush_id_ex   = mis;
      redirect_pc   = !mis ? '0 : ex_taken ? ex_target : ex_pc + XLEN'(4);
      busy_recover  = rst_n & (state_q == RECOVER);
      // Table read above uses the old contents, so a same-index update is seen next cycle.
      bht_d = bht_q;
      if (res)
         bht_d[ex_idx] = ex_taken ? (ctr == 2'b11 ? ctr : ctr + 2'd1)
                                  : (ctr == 2'b00 ? ctr : ctr - 2'd1);
      branch_cnt_d  = branch_cnt_q + 32'(res);
      mispred_cnt_d = mispred_cnt_q + 32'(mis);
      state_d       = state_q;
      rec_cnt_d     = rec_cnt_q;
      if (mis) begin
         state_d   = RECOVER;
         rec_cnt_d = 2'd2;
      end else if (state_q == RECOVER) begin
         rec_cnt_d = rec_cnt_q - 2'd1;
         state_d   = rec_cnt_d == 2'd0 ? RUN : RECOVER;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bht_q         <= '{default: 2'b01};
         state_q       <= RUN;
         rec_cnt_q     <= 2'd0;
         branch_cnt_q  <= 32'd0;
         mispred_cnt_q <= 32'd0;
      end else begin
         bht_q         <= bht_d;
         state_q       <= state_d;
         rec_cnt_q     <= rec_cnt_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end
   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;
endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
Branch scheduling and recovery controller for the pipelined core. It sits between the IF stage and the EX-stage branch resolver (funct3 plus ALU flags producing the taken signal). It holds a small bimodal history table (2-bit saturating counters) that predicts taken/not-taken at fetch. It compares the EX-stage resolved outcome with the carried prediction, drives PC redirect and pipeline flushes on a mispredict, and runs a short recovery FSM. It also maintains branch and mispredict performance counters.

Parameters:
IDX_W, 4, BHT index width; table has 2^IDX_W entries, indexed by pc[IDX_W+1:2]
XLEN, 32, PC/address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous, active-low reset
if_pc  in  XLEN  PC of the instruction in IF
if_is_branch  in  1  predecode: IF instruction is a conditional branch
if_pred_taken  out  1  prediction for IF instruction
ex_valid  in  1  EX stage holds a real (non-bubble) instruction
ex_is_branch  in  1  EX instruction is a conditional branch
ex_pc  in  XLEN  PC of the EX instruction
ex_pred_taken  in  1  prediction carried down the pipe with the EX instruction
ex_taken  in  1  resolved outcome from the branch resolver
ex_target  in  XLEN  computed branch target
redirect  out  1  override next PC this cycle
redirect_pc  out  XLEN  next PC when redirect=1
flush_if_id  out  1  squash IF/ID register at next edge
flush_id_ex  out  1  squash ID/EX register at next edge
busy_recover  out  1  FSM in RECOVER
branch_cnt  out  32  resolved branches counted
mispred_cnt  out  32  mispredicts counted

Behaviour:
- Reset (rst_n=0 at an edge): every BHT entry = 2'b01 (weakly not-taken); state=RUN; recovery counter=0; branch_cnt=0; mispred_cnt=0. While rst_n=0, redirect, flush_if_id, flush_id_ex, if_pred_taken and busy_recover are forced to 0 and redirect_pc=0. Reset mid-recovery abandons recovery immediately.
- Prediction (combinational, 0-cycle): idx=if_pc[IDX_W+1:2]; if_pred_taken = if_is_branch & BHT[idx][1]. No bypass: a same-cycle update to the same index is not visible until the next cycle.
- Resolve event: res = ex_valid & ex_is_branch & (state==RUN).
- Mispredict: mis = res & (ex_taken != ex_pred_taken).
- When mis=1, in the same cycle (combinational): redirect=1; flush_if_id=1; flush_id_ex=1; redirect_pc = ex_taken ? ex_target : ex_pc+4 (modulo 2^XLEN, wraps silently). Otherwise redirect, flushes and redirect_pc are all 0.
- BHT update at the edge when res=1, at idx=ex_pc[IDX_W+1:2]:
  - taken: increment, saturating at 2'b11.
  - not taken: decrement, saturating at 2'b00.
  - Updates happen whether or not the branch mispredicted.
- Counters at the edge:
  - branch_cnt += 1 when res=1.
  - mispred_cnt += 1 when mis=1.
  - Both wrap from 2^32-1 to 0.
- FSM:
  - RUN -> RECOVER on mis; load recovery counter=2.
  - RECOVER: decrement the counter each cycle; return to RUN when the counter reaches 0. RECOVER lasts exactly 2 cycles, covering the two squashed slots.
  - In RECOVER: res=0, so no BHT updates, no counting and no redirect, even if ex_valid & ex_is_branch are high.
  - busy_recover=1 iff state==RECOVER.
- Non-branch or invalid EX (ex_valid=0 or ex_is_branch=0): no update, no redirect; ex_taken is ignored.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with if_is_branch=1 and if_pc=0x40 -> if_pred_taken=0, all outputs 0, counters 0. After release, if_pred_taken=0 (entry 2'b01).
- Mispredict taken: ex_valid=ex_is_branch=1, ex_pc=0x100, ex_pred_taken=0, ex_taken=1, ex_target=0x200 -> same cycle redirect=1, redirect_pc=0x200, both flushes=1. Next 2 cycles busy_recover=1. mispred_cnt=1, branch_cnt=1. Entry idx 0 becomes 2'b10, so if_pc=0x100 now predicts taken.
- Mispredict not-taken with wrap: ex_pc=0xFFFFFFFC, ex_pred_taken=1, ex_taken=0 -> redirect_pc=0x00000000.
- Saturation: 4 consecutive correctly-predicted taken resolutions at ex_pc=0x8 (stay in RUN) -> counter 2'b11 with no redirect. Then 1 not-taken -> 2'b10, prediction still taken.
- Masking in RECOVER: assert a mispredicting branch in both cycles after a mispredict -> no redirect, no BHT change, counters unchanged. Third cycle: a resolve is accepted.
- Read/write same index: IF at 0x10 while EX updates 0x10 from 2'b01 to 2'b10 -> if_pred_taken=0 that cycle, 1 next cycle.
